// File: rtl/z80_rp_incdec_seq.sv
// Byte-fed sequencer for Z80 16-bit register-pair INC/DEC with DD/FD prefix chains.
// Optional feature macro: RP_INCDEC_WRAP_EN adds the o_wrap output.
module z80_rp_incdec_seq #(
    parameter int WIDTH      = 16,
    parameter int LATENCY    = 2,
    parameter int MAX_PREFIX = 4,
    localparam int PC_W      = $clog2(MAX_PREFIX + 2)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [7:0]       i_op_byte,
    input  logic [WIDTH-1:0] i_bc,
    input  logic [WIDTH-1:0] i_de,
    input  logic [WIDTH-1:0] i_hl,
    input  logic [WIDTH-1:0] i_sp,
    input  logic [WIDTH-1:0] i_ix,
    input  logic [WIDTH-1:0] i_iy,
    output logic             o_wr_valid,
    output logic [2:0]       o_wr_sel,
    output logic [WIDTH-1:0] o_wr_data,
    output logic [PC_W-1:0]  o_pc_inc,
    output logic             o_illegal,
    output logic             o_busy
`ifdef RP_INCDEC_WRAP_EN
    ,
    output logic             o_wrap
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_PREFIX, ST_EXEC, ST_WB} state_t;

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [PC_W-1:0]  PC_MAX    = PC_W'(MAX_PREFIX);
    localparam logic [PC_W-1:0]  PC_OVF    = PC_W'(MAX_PREFIX + 1);

    state_t           state_reg;
    logic [PC_W-1:0]  count_reg;
    logic             idx_iy_reg;
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [2:0]       sel_hold_reg;
    logic [WIDTH-1:0] res_hold_reg;

    logic             wr_valid_reg;
    logic [2:0]       wr_sel_reg;
    logic [WIDTH-1:0] wr_data_reg;
    logic [PC_W-1:0]  pc_inc_reg;
    logic             illegal_reg;

    logic             accept;
    logic             is_prefix;
    logic             is_match;
    logic [PC_W-1:0]  count_inc;
    logic [2:0]       sel_next;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] res_next;

    assign o_op_ready = ~i_reset & ((state_reg == ST_IDLE) || (state_reg == ST_PREFIX));
    assign o_busy     = (state_reg != ST_IDLE);
    assign accept     = i_op_valid & o_op_ready;
    assign is_prefix  = (i_op_byte == 8'hDD) || (i_op_byte == 8'hFD);
    assign is_match   = (i_op_byte[7:6] == 2'b00) && (i_op_byte[2:0] == 3'b011);
    assign count_inc  = count_reg + PC_W'(1);

    assign o_wr_valid = wr_valid_reg;
    assign o_wr_sel   = wr_sel_reg;
    assign o_wr_data  = wr_data_reg;
    assign o_pc_inc   = pc_inc_reg;
    assign o_illegal  = illegal_reg;

    // Only HL is redirected by an index prefix; count_reg is zero in IDLE so no prefix applies there.
    always_comb begin
        sel_next = 3'd0;
        operand  = i_bc;
        case (i_op_byte[5:4])
            2'd0: begin
                sel_next = 3'd0;
                operand  = i_bc;
            end
            2'd1: begin
                sel_next = 3'd1;
                operand  = i_de;
            end
            2'd2: begin
                if (count_reg != '0) begin
                    sel_next = idx_iy_reg ? 3'd5 : 3'd4;
                    operand  = idx_iy_reg ? i_iy : i_ix;
                end else begin
                    sel_next = 3'd2;
                    operand  = i_hl;
                end
            end
            default: begin
                sel_next = 3'd3;
                operand  = i_sp;
            end
        endcase
        res_next = i_op_byte[3] ? (operand - WIDTH'(1)) : (operand + WIDTH'(1));
    end

`ifdef RP_INCDEC_WRAP_EN
    logic wrap_next;
    logic wrap_hold_reg;
    logic wrap_reg;

    assign wrap_next = i_op_byte[3] ? (operand == '0) : (operand == '1);
    assign o_wrap    = wrap_reg;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            idx_iy_reg   <= 1'b0;
            exec_cnt_reg <= '0;
            sel_hold_reg <= '0;
            res_hold_reg <= '0;
            wr_valid_reg <= 1'b0;
            wr_sel_reg   <= '0;
            wr_data_reg  <= '0;
            pc_inc_reg   <= '0;
            illegal_reg  <= 1'b0;
`ifdef RP_INCDEC_WRAP_EN
            wrap_hold_reg <= 1'b0;
            wrap_reg      <= 1'b0;
`endif
        end else begin
            // Result outputs are single-cycle pulses and read as zero otherwise.
            wr_valid_reg <= 1'b0;
            wr_sel_reg   <= '0;
            wr_data_reg  <= '0;
            pc_inc_reg   <= '0;
            illegal_reg  <= 1'b0;
`ifdef RP_INCDEC_WRAP_EN
            wrap_reg     <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE, ST_PREFIX: begin
                    if (accept) begin
                        if (is_prefix) begin
                            if (count_reg == PC_MAX) begin
                                illegal_reg <= 1'b1;
                                pc_inc_reg  <= PC_OVF;
                                state_reg   <= ST_IDLE;
                                count_reg   <= '0;
                                idx_iy_reg  <= 1'b0;
                            end else begin
                                count_reg  <= count_inc;
                                idx_iy_reg <= (i_op_byte == 8'hFD);
                                state_reg  <= ST_PREFIX;
                            end
                        end else if (is_match) begin
                            // Snapshot the result now so later register-file changes cannot leak in.
                            sel_hold_reg <= sel_next;
                            res_hold_reg <= res_next;
                            exec_cnt_reg <= '0;
`ifdef RP_INCDEC_WRAP_EN
                            wrap_hold_reg <= wrap_next;
`endif
                            if (LATENCY == 1) begin
                                state_reg    <= ST_WB;
                                wr_valid_reg <= 1'b1;
                                wr_sel_reg   <= sel_next;
                                wr_data_reg  <= res_next;
                                pc_inc_reg   <= count_inc;
`ifdef RP_INCDEC_WRAP_EN
                                wrap_reg     <= wrap_next;
`endif
                            end else begin
                                state_reg <= ST_EXEC;
                            end
                        end else begin
                            illegal_reg <= 1'b1;
                            pc_inc_reg  <= count_inc;
                            state_reg   <= ST_IDLE;
                            count_reg   <= '0;
                            idx_iy_reg  <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt_reg == EXEC_LAST) begin
                        state_reg    <= ST_WB;
                        wr_valid_reg <= 1'b1;
                        wr_sel_reg   <= sel_hold_reg;
                        wr_data_reg  <= res_hold_reg;
                        pc_inc_reg   <= count_inc;
`ifdef RP_INCDEC_WRAP_EN
                        wrap_reg     <= wrap_hold_reg;
`endif
                    end else begin
                        exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    count_reg  <= '0;
                    idx_iy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_rp_incdec_seq.sv
// Directed bench for z80_rp_incdec_seq: hand-computed INC/DEC, prefix, illegal and reset cases.
module tb_z80_rp_incdec_seq;

    localparam int WIDTH      = 16;
    localparam int LATENCY    = 2;
    localparam int MAX_PREFIX = 4;
    localparam int PC_W       = $clog2(MAX_PREFIX + 2);

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_op_valid;
    logic             o_op_ready;
    logic [7:0]       i_op_byte;
    logic [WIDTH-1:0] i_bc, i_de, i_hl, i_sp, i_ix, i_iy;
    logic             o_wr_valid;
    logic [2:0]       o_wr_sel;
    logic [WIDTH-1:0] o_wr_data;
    logic [PC_W-1:0]  o_pc_inc;
    logic             o_illegal;
    logic             o_busy;
`ifdef RP_INCDEC_WRAP_EN
    logic             o_wrap;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_rp_incdec_seq #(
        .WIDTH      (WIDTH),
        .LATENCY    (LATENCY),
        .MAX_PREFIX (MAX_PREFIX)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_op_valid (i_op_valid),
        .o_op_ready (o_op_ready),
        .i_op_byte  (i_op_byte),
        .i_bc       (i_bc),
        .i_de       (i_de),
        .i_hl       (i_hl),
        .i_sp       (i_sp),
        .i_ix       (i_ix),
        .i_iy       (i_iy),
        .o_wr_valid (o_wr_valid),
        .o_wr_sel   (o_wr_sel),
        .o_wr_data  (o_wr_data),
        .o_pc_inc   (o_pc_inc),
        .o_illegal  (o_illegal),
        .o_busy     (o_busy)
`ifdef RP_INCDEC_WRAP_EN
        ,
        .o_wrap     (o_wrap)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic put(input logic [7:0] b);
        i_op_valid = 1'b1;
        i_op_byte  = b;
        @(negedge clk);
        check("ready_at_put", o_op_ready, 1);
        @(posedge clk);
        #1;
        i_op_valid = 1'b0;
        i_op_byte  = 8'h00;
    endtask

    task automatic expect_wb(input string tag, input logic [2:0] sel, input logic [15:0] data,
                             input logic [2:0] pc, input logic wrap);
        int   cyc = 0;
        logic ill = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (o_illegal) ill = 1'b1;
        end while (!o_wr_valid && cyc < 8);
        check({tag, ".latency"}, cyc, LATENCY);
        check({tag, ".illegal"}, ill, 0);
        check({tag, ".sel"}, o_wr_sel, sel);
        check({tag, ".data"}, o_wr_data, data);
        check({tag, ".pc_inc"}, o_pc_inc, pc);
        check({tag, ".busy_wb"}, o_busy, 1);
        check({tag, ".ready_wb"}, o_op_ready, 0);
`ifdef RP_INCDEC_WRAP_EN
        check({tag, ".wrap"}, o_wrap, wrap);
`endif
        $display("txn %s sel=%0d data=%h pc_inc=%0d wrap_exp=%0d", tag, o_wr_sel, o_wr_data, o_pc_inc, wrap);
        @(negedge clk);
        check({tag, ".valid_after"}, o_wr_valid, 0);
        check({tag, ".data_after"}, o_wr_data, 0);
        check({tag, ".ready_after"}, o_op_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_illegal(input string tag, input logic [2:0] pc);
        @(negedge clk);
        check({tag, ".illegal"}, o_illegal, 1);
        check({tag, ".pc_inc"}, o_pc_inc, pc);
        check({tag, ".valid"}, o_wr_valid, 0);
        check({tag, ".busy"}, o_busy, 0);
        check({tag, ".ready"}, o_op_ready, 1);
        $display("txn %s illegal=%0d pc_inc=%0d", tag, o_illegal, o_pc_inc);
        @(negedge clk);
        check({tag, ".illegal_after"}, o_illegal, 0);
        check({tag, ".pc_after"}, o_pc_inc, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset    = 1'b1;
        i_op_valid = 1'b0;
        i_op_byte  = 8'h00;
        i_bc = 16'h1111; i_de = 16'h2222; i_hl = 16'h3333;
        i_sp = 16'h4444; i_ix = 16'h5555; i_iy = 16'h6666;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", o_op_ready, 0);
        check("rst.valid", o_wr_valid, 0);
        check("rst.illegal", o_illegal, 0);
        check("rst.busy", o_busy, 0);
        check("rst.data", o_wr_data, 0);
        check("rst.pc_inc", o_pc_inc, 0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("rst.ready_release", o_op_ready, 1);
        $display("txn reset released ready=%0d", o_op_ready);
        @(posedge clk);
        #1;

        // Prefix before BC is consumed and ignored
        i_bc = 16'h789A;
        put(8'hFD);
        check("fd03.busy_prefix", o_busy, 1);
        put(8'h03);
        expect_wb("fd03", 3'd0, 16'h789B, 3'd2, 1'b0);

        // Indexed HL
        i_ix = 16'h1000;
        put(8'hDD); put(8'h23);
        expect_wb("dd23", 3'd4, 16'h1001, 3'd2, 1'b0);
        i_iy = 16'h0000;
        put(8'hFD); put(8'h2B);
        expect_wb("fd2b", 3'd5, 16'hFFFF, 3'd2, 1'b1);

        // Last prefix wins, both directions
        i_hl = 16'h1234; i_iy = 16'h00FF;
        put(8'hDD); put(8'hFD); put(8'h23);
        expect_wb("ddfd23", 3'd5, 16'h0100, 3'd3, 1'b0);
        i_ix = 16'hABCD;
        put(8'hFD); put(8'hDD); put(8'h23);
        expect_wb("fddd23", 3'd4, 16'hABCE, 3'd3, 1'b0);

        // Unprefixed pairs, snapshot held despite a later SP change
        i_sp = 16'hFFFF;
        put(8'h33);
        i_sp = 16'h5555;
        expect_wb("33", 3'd3, 16'h0000, 3'd1, 1'b1);
        i_de = 16'h8000;
        put(8'h1B);
        expect_wb("1b", 3'd1, 16'h7FFF, 3'd1, 1'b0);
        i_hl = 16'h0001;
        put(8'h2B);
        expect_wb("2b", 3'd2, 16'h0000, 3'd1, 1'b0);
        i_bc = 16'h0000;
        put(8'hDD); put(8'h0B);
        expect_wb("dd0b", 3'd0, 16'hFFFF, 3'd2, 1'b1);
        i_sp = 16'h0001;
        put(8'hFD); put(8'h3B);
        expect_wb("fd3b", 3'd3, 16'h0000, 3'd2, 1'b0);

        // Prefix state held while no byte is offered
        i_iy = 16'h7FFF;
        put(8'hFD);
        repeat (5) @(posedge clk);
        #1;
        check("hold.busy", o_busy, 1);
        check("hold.ready", o_op_ready, 1);
        put(8'h23);
        expect_wb("fd_wait_23", 3'd5, 16'h8000, 3'd2, 1'b0);

        // Illegal bytes and prefix overflow
        put(8'h00);
        expect_illegal("ill00", 3'd1);
        put(8'hDD); put(8'h76);
        expect_illegal("dd76", 3'd2);
        for (int i = 0; i < MAX_PREFIX + 1; i++) put(8'hFD);
        expect_illegal("fdx5", 3'd5);

        // Reset during EXEC abandons the instruction
        i_bc = 16'h4321;
        put(8'hDD); put(8'h03);
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstx.valid", o_wr_valid, 0);
        check("rstx.illegal", o_illegal, 0);
        check("rstx.sel", o_wr_sel, 0);
        check("rstx.data", o_wr_data, 0);
        check("rstx.pc_inc", o_pc_inc, 0);
        check("rstx.busy", o_busy, 0);
        check("rstx.ready", o_op_ready, 0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("rstx.ready_release", o_op_ready, 1);
        check("rstx.valid_release", o_wr_valid, 0);
        $display("txn reset during exec ready=%0d valid=%0d", o_op_ready, o_wr_valid);
        @(posedge clk);
        #1;
        i_bc = 16'h0000;
        put(8'h03);
        expect_wb("post_rst03", 3'd0, 16'h0001, 3'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
